// File: rtl/ro_freq_counter_if.sv
// Measurement request / result handshake between a frequency-meter controller
// (master) and ro_freq_counter (slave).
interface ro_freq_counter_if #(
  parameter int CNT_W  = 24,
  parameter int GATE_W = 20
);
  logic              start;
  logic [GATE_W-1:0] gate_cycles;
  logic              busy;
  logic              result_valid;
  logic              result_ready;
  logic [CNT_W-1:0]  result_count;
  logic              overflow;

  modport master (
    output start, gate_cycles, result_ready,
    input  busy, result_valid, result_count, overflow
  );

  modport slave (
    input  start, gate_cycles, result_ready,
    output busy, result_valid, result_count, overflow
  );
endinterface

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency meter: counts synchronized rising edges of ro_in
// over a window of gate_cycles wb_clk_i cycles and returns them via valid/ready.
module ro_freq_counter #(
  parameter int CNT_W       = 24,
  parameter int GATE_W      = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             ro_in,
  ro_freq_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GATE_W-1:0]      win_q, win_d;
  logic                   ovf_q, ovf_d;
  logic                   rise;

  // Synchronizer and edge history run in every state, independent of the FSM.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ro_in};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cnt_d   = '0;
          ovf_d   = 1'b0;
          win_d   = bus.gate_cycles;
          state_d = (bus.gate_cycles == '0) ? HOLD : COUNT;
        end
      end
      COUNT: begin
        win_d = win_q - GATE_W'(1);
        // A rise arriving while already at all-ones is a lost edge.
        if (rise) begin
          if (&cnt_q) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (win_q == GATE_W'(1)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.result_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      sync_q  <= '0;
      hist_q  <= 1'b0;
      cnt_q   <= '0;
      win_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      ovf_q   <= ovf_d;
    end
  end

  // The edge counter only moves in COUNT, so it doubles as the held result.
  assign bus.busy         = (state_q != IDLE);
  assign bus.result_valid = (state_q == HOLD);
  assign bus.result_count = cnt_q;
  assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed self-checking bench for ro_freq_counter: a 24-bit instance for the
// main scenarios and a 4-bit instance for counter saturation.
module tb_ro_freq_counter;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic ro_in    = 1'b0;
  logic ro_level = 1'b0;
  int   ro_mode  = 0;
  int   ph       = 0;
  int   passed   = 0;
  int   total    = 0;

  ro_freq_counter_if #(.CNT_W(24), .GATE_W(20)) bus ();
  ro_freq_counter_if #(.CNT_W(4),  .GATE_W(20)) bus4 ();

  ro_freq_counter #(.CNT_W(24), .GATE_W(20), .SYNC_STAGES(2)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .ro_in    (ro_in),
    .bus      (bus.slave)
  );

  ro_freq_counter #(.CNT_W(4), .GATE_W(20), .SYNC_STAGES(2)) dut4 (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .ro_in    (ro_in),
    .bus      (bus4.slave)
  );

  always #5 clk = ~clk;

  // Oscillator model: 0 = manual level, 1 = period 8 (4 high/4 low), 2 = toggle each clock.
  always @(posedge clk) begin
    #2;
    ph = ph + 1;
    case (ro_mode)
      1:       ro_in = ((ph % 8) < 4);
      2:       ro_in = ((ph % 2) == 1);
      default: ro_in = ro_level;
    endcase
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_meas(input bit use4, input int g);
    @(posedge clk);
    #1;
    if (use4) begin
      bus4.start       = 1'b1;
      bus4.gate_cycles = 20'(g);
    end else begin
      bus.start        = 1'b1;
      bus.gate_cycles  = 20'(g);
    end
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus4.start = 1'b0;
  endtask

  task automatic wait_valid(input bit use4, input int limit, output int busy_cycles, output bit ok);
    busy_cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (use4 ? bus4.result_valid : bus.result_valid) begin
        ok = 1'b1;
        break;
      end
      if (use4 ? bus4.busy : bus.busy) busy_cycles++;
    end
  endtask

  task automatic handshake(input bit use4);
    if (use4) bus4.result_ready = 1'b1;
    else      bus.result_ready  = 1'b1;
    @(posedge clk);
    #1;
    bus.result_ready  = 1'b0;
    bus4.result_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
      $display("[TB] FAIL reset_flags: busy=%b valid=%b required 0 0", bus.busy, bus.result_valid);
    end else passed++;
    total++;
    if (bus.result_count !== 24'd0 || bus.overflow !== 1'b0) begin
      $display("[TB] FAIL reset_result: count=%0d ovf=%b required 0 0", bus.result_count, bus.overflow);
    end else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_period8();
    int n;
    bit ok;
    ro_mode = 1;
    tick(4);
    start_meas(1'b0, 800);
    bus.gate_cycles = 20'd3;
    wait_valid(1'b0, 2000, n, ok);
    total++;
    if (!ok || n != 800) begin
      $display("[TB] FAIL p8_window: busy cycles=%0d ok=%b required 800 1", n, ok);
    end else passed++;
    total++;
    if (bus.result_count < 24'd99 || bus.result_count > 24'd101) begin
      $display("[TB] FAIL p8_count: got %0d required 99..101", bus.result_count);
    end else passed++;
    total++;
    if (bus.overflow !== 1'b0) begin
      $display("[TB] FAIL p8_ovf: got %b required 0", bus.overflow);
    end else passed++;
    handshake(1'b0);
    @(negedge clk);
    total++;
    if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.result_count < 24'd99 || bus.result_count > 24'd101) begin
      $display("[TB] FAIL p8_after: valid=%b busy=%b count=%0d required 0 0 99..101",
               bus.result_valid, bus.busy, bus.result_count);
    end else passed++;
  endtask

  task automatic test_steady_and_step();
    int n;
    bit ok;
    ro_mode  = 0;
    ro_level = 1'b1;
    tick(5);
    start_meas(1'b0, 1000);
    wait_valid(1'b0, 2000, n, ok);
    total++;
    if (!ok || bus.result_count !== 24'd0 || bus.overflow !== 1'b0) begin
      $display("[TB] FAIL steady_high: ok=%b count=%0d ovf=%b required 1 0 0", ok, bus.result_count, bus.overflow);
    end else passed++;
    handshake(1'b0);
    ro_level = 1'b0;
    tick(5);
    ro_level = 1'b1;
    start_meas(1'b0, 10);
    wait_valid(1'b0, 100, n, ok);
    total++;
    if (!ok || bus.result_count !== 24'd1) begin
      $display("[TB] FAIL step_edge: ok=%b count=%0d required 1 1", ok, bus.result_count);
    end else passed++;
    handshake(1'b0);
  endtask

  task automatic test_overflow();
    int n;
    bit ok;
    ro_mode = 2;
    tick(4);
    start_meas(1'b1, 64);
    wait_valid(1'b1, 200, n, ok);
    total++;
    if (!ok || bus4.result_count !== 4'd15 || bus4.overflow !== 1'b1) begin
      $display("[TB] FAIL ovf_sat: ok=%b count=%0d ovf=%b required 1 15 1", ok, bus4.result_count, bus4.overflow);
    end else passed++;
    handshake(1'b1);
    start_meas(1'b1, 10);
    wait_valid(1'b1, 100, n, ok);
    total++;
    if (!ok || bus4.overflow !== 1'b0 || bus4.result_count < 4'd4 || bus4.result_count > 4'd6) begin
      $display("[TB] FAIL ovf_clear: ok=%b count=%0d ovf=%b required 1 4..6 0", ok, bus4.result_count, bus4.overflow);
    end else passed++;
    handshake(1'b1);
    ro_mode = 0;
    ro_level = 1'b0;
  endtask

  task automatic test_zero_gate();
    ro_mode = 1;
    @(posedge clk);
    #1;
    bus.start       = 1'b1;
    bus.gate_cycles = 20'd0;
    @(negedge clk);
    total++;
    if (bus.result_valid !== 1'b0) begin
      $display("[TB] FAIL zero_pre: valid=%b required 0", bus.result_valid);
    end else passed++;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    total++;
    if (bus.result_valid !== 1'b1 || bus.result_count !== 24'd0 || bus.overflow !== 1'b0) begin
      $display("[TB] FAIL zero_gate: valid=%b count=%0d ovf=%b required 1 0 0",
               bus.result_valid, bus.result_count, bus.overflow);
    end else passed++;
    @(posedge clk);
    #1;
    bus.start       = 1'b1;
    bus.gate_cycles = 20'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    tick(6);
    @(negedge clk);
    total++;
    if (bus.result_valid !== 1'b1 || bus.busy !== 1'b1 || bus.result_count !== 24'd0) begin
      $display("[TB] FAIL zero_hold_start: valid=%b busy=%b count=%0d required 1 1 0",
               bus.result_valid, bus.busy, bus.result_count);
    end else passed++;
    handshake(1'b0);
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
      $display("[TB] FAIL zero_release: busy=%b valid=%b required 0 0", bus.busy, bus.result_valid);
    end else passed++;
    ro_mode = 0;
    ro_level = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    bit ok;
    ro_mode  = 0;
    ro_level = 1'b0;
    tick(4);
    start_meas(1'b0, 30);
    tick(4);
    ro_level = 1'b1;
    tick(4);
    ro_level = 1'b0;
    tick(4);
    ro_level = 1'b1;
    tick(4);
    ro_level = 1'b0;
    wait_valid(1'b0, 100, n, ok);
    total++;
    if (!ok || bus.result_count !== 24'd2) begin
      $display("[TB] FAIL bp_count: ok=%b count=%0d required 1 2", ok, bus.result_count);
    end else passed++;
    ro_mode = 2;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      bus.start       = ((i % 3) == 0);
      bus.gate_cycles = 20'd7;
      @(negedge clk);
      total++;
      if (bus.result_valid !== 1'b1 || bus.result_count !== 24'd2 || bus.overflow !== 1'b0) begin
        $display("[TB] FAIL bp_hold[%0d]: valid=%b count=%0d ovf=%b required 1 2 0",
                 i, bus.result_valid, bus.result_count, bus.overflow);
      end else passed++;
    end
    bus.start        = 1'b1;
    bus.result_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.start        = 1'b0;
    bus.result_ready = 1'b0;
    @(negedge clk);
    total++;
    if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result_count !== 24'd2) begin
      $display("[TB] FAIL bp_transfer: valid=%b busy=%b count=%0d required 0 0 2",
               bus.result_valid, bus.busy, bus.result_count);
    end else passed++;
    ro_mode = 0;
  endtask

  task automatic test_reset_mid_count();
    int n;
    bit ok;
    ro_mode = 1;
    start_meas(1'b0, 1000);
    tick(100);
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b1 || bus.result_count == 24'd0) begin
      $display("[TB] FAIL mid_running: busy=%b count=%0d required 1 nonzero", bus.busy, bus.result_count);
    end else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 ||
        bus.result_count !== 24'd0 || bus.overflow !== 1'b0) begin
      $display("[TB] FAIL async_reset: busy=%b valid=%b count=%0d ovf=%b required 0 0 0 0",
               bus.busy, bus.result_valid, bus.result_count, bus.overflow);
    end else passed++;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(3);
    start_meas(1'b0, 80);
    wait_valid(1'b0, 200, n, ok);
    total++;
    if (!ok || bus.result_count < 24'd9 || bus.result_count > 24'd11) begin
      $display("[TB] FAIL post_reset: ok=%b count=%0d required 1 9..11", ok, bus.result_count);
    end else passed++;
    handshake(1'b0);
  endtask

  initial begin
    bus.start         = 1'b0;
    bus.gate_cycles   = '0;
    bus.result_ready  = 1'b0;
    bus4.start        = 1'b0;
    bus4.gate_cycles  = '0;
    bus4.result_ready = 1'b0;
    test_reset();
    test_period8();
    test_steady_and_step();
    test_overflow();
    test_zero_gate();
    test_backpressure();
    test_reset_mid_count();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
